// File: rtl/dsp_sensor_pkg.sv
// Shared types and widths for the DSP delay-sensor calibrator.
package dsp_sensor_pkg;
  localparam int TAP_W = 5;
  localparam int P_W   = 48;
  localparam int HW_W  = 6;

  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_ACCUM,
    ST_EVAL,
    ST_APPLY,
    ST_LOCKED
  } state_t;
endpackage

// File: rtl/dsp_sensor_calibrator_if.sv
// Host-side control/status and trace stream of the sensor calibrator.
interface dsp_sensor_calibrator_if #(
  parameter int SAMPLE_LOG2 = 4
) ();
  // start is a one-cycle request with no ready; busy/done report progress.
  // The trace stream is valid-only: trace_hw is a new sample on every cycle
  // that trace_valid is high, and the consumer cannot stall it.
  logic                                   start;
  logic                                   busy;
  logic                                   done;
  logic [dsp_sensor_pkg::TAP_W-1:0]       best_taps_clk;
  logic [dsp_sensor_pkg::TAP_W-1:0]       best_taps_A;
  logic [dsp_sensor_pkg::HW_W+SAMPLE_LOG2-1:0] best_err;
  logic                                   trace_valid;
  logic [dsp_sensor_pkg::HW_W-1:0]        trace_hw;

  modport master (
    output start,
    input  busy, done, best_taps_clk, best_taps_A, best_err, trace_valid, trace_hw
  );

  modport slave (
    input  start,
    output busy, done, best_taps_clk, best_taps_A, best_err, trace_valid, trace_hw
  );
endinterface

// File: rtl/popcount48.sv
// Registered population count of a 48-bit word, one cycle of latency.
module popcount48
  import dsp_sensor_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [P_W-1:0]  d,
  output logic [HW_W-1:0] q
);
  logic [HW_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < P_W; i++) sum = sum + HW_W'(d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= sum;
  end
endmodule

// File: rtl/dsp_sensor_calibrator.sv
// Sweeps both IDELAY taps, picks the point whose mean Hamming weight is
// closest to TARGET_HW, locks there and streams Hamming-weight samples.
module dsp_sensor_calibrator
  import dsp_sensor_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_LOG2   = 4,
  parameter int TARGET_HW     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [P_W-1:0]    sensor_p,
  output logic [TAP_W-1:0]  taps_clk,
  output logic [TAP_W-1:0]  taps_A,
  dsp_sensor_calibrator_if.slave host,
  output state_t            dbg_state
);
  localparam int N       = 1 << SAMPLE_LOG2;
  localparam int AW      = HW_W + SAMPLE_LOG2;
  localparam int CNT_MAX = (SETTLE_CYCLES > N) ? SETTLE_CYCLES : N;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [AW-1:0] TGT = AW'(TARGET_HW * N);

  state_t           state, state_n;
  logic [P_W-1:0]   p_q;
  logic [HW_W-1:0]  hw;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, err, best_err;
  logic [TAP_W-1:0] best_clk, best_a;
  logic             start_sweep, cnt_clr, cnt_inc, acc_clr, acc_add, eval;
  logic             improve, last_point;

  // Free-running input pipeline; sensor_p is synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= sensor_p;
  end

  popcount48 u_popcount (.clk(clk), .rst_n(rst_n), .d(p_q), .q(hw));

  assign err        = (acc >= TGT) ? (acc - TGT) : (TGT - acc);
  assign improve    = err < best_err;
  assign last_point = (taps_A == TAP_MAX) && (taps_clk == TAP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_sweep = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    eval        = 1'b0;
    case (state)
      ST_IDLE, ST_LOCKED: begin
        if (host.start) begin
          start_sweep = 1'b1;
          state_n     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_clr = 1'b1;
        acc_clr = 1'b1;
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_clr = 1'b1;
          state_n = ST_ACCUM;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_ACCUM: begin
        acc_add = 1'b1;
        if (cnt == CW'(N - 1)) begin
          cnt_clr = 1'b1;
          state_n = ST_EVAL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_EVAL: begin
        eval    = 1'b1;
        cnt_clr = 1'b1;
        state_n = last_point ? ST_APPLY : ST_LOAD;
      end
      ST_APPLY: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = ST_LOCKED;
        else                               cnt_inc = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      taps_clk <= '0;
      taps_A   <= '0;
      best_clk <= '0;
      best_a   <= '0;
      best_err <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);

      if (acc_clr)      acc <= '0;
      else if (acc_add) acc <= acc + AW'(hw);

      if (start_sweep) begin
        taps_clk <= '0;
        taps_A   <= '0;
        best_clk <= '0;
        best_a   <= '0;
        best_err <= '1;
      end else if (eval) begin
        // Strict compare keeps the earliest point on ties.
        if (improve) begin
          best_err <= err;
          best_clk <= taps_clk;
          best_a   <= taps_A;
        end
        if (last_point) begin
          // The last point may itself be the new best, so use the fresh value.
          taps_clk <= improve ? taps_clk : best_clk;
          taps_A   <= improve ? taps_A   : best_a;
        end else begin
          taps_clk <= taps_clk + TAP_W'(1);
          if (taps_clk == TAP_MAX) taps_A <= taps_A + TAP_W'(1);
        end
      end
    end
  end

  assign host.busy          = (state != ST_IDLE) && (state != ST_LOCKED);
  assign host.done          = (state == ST_LOCKED);
  assign host.trace_valid   = (state == ST_LOCKED);
  assign host.trace_hw      = hw;
  assign host.best_taps_clk = best_clk;
  assign host.best_taps_A   = best_a;
  assign host.best_err      = best_err;
  assign dbg_state          = state;
endmodule

// File: tb/tb_dsp_sensor_calibrator.sv
// Directed bench for dsp_sensor_calibrator with a tap-dependent sensor model.
module tb_dsp_sensor_calibrator;
  import dsp_sensor_pkg::*;

  localparam int S   = 4;
  localparam int LG  = 2;
  localparam int N   = 1 << LG;
  localparam int PT  = 2 + S + N;
  // Cycle index (first LOAD cycle = 1) at which done is first seen.
  localparam int DONE_AT = 1024 * PT + S + 1;
  localparam logic [47:0] ONES24 = 48'h0000_00FF_FFFF;
  localparam logic [47:0] ONES48 = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] sensor_p;
  logic [4:0]  taps_clk, taps_A;
  state_t      dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mode = 0;
  logic        tog = 1'b0;
  logic [47:0] manual_p = '0;

  dsp_sensor_calibrator_if #(.SAMPLE_LOG2(LG)) cal_if ();

  dsp_sensor_calibrator #(
    .SETTLE_CYCLES(S), .SAMPLE_LOG2(LG), .TARGET_HW(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensor_p(sensor_p),
    .taps_clk(taps_clk), .taps_A(taps_A), .host(cal_if), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(negedge clk) tog = ~tog;

  // Sensor model: output depends on the taps currently applied.
  always_comb begin
    sensor_p = '0;
    case (mode)
      0: sensor_p = (taps_A == 5'd5 && taps_clk == 5'd17) ? ONES24 : '0;
      1: sensor_p = ((taps_A == 5'd2 && taps_clk == 5'd3) ||
                     (taps_A == 5'd9 && taps_clk == 5'd9)) ? ONES24 : '0;
      2: sensor_p = tog ? ONES48 : '0;
      default: sensor_p = manual_p;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the first cycle after start acceptance.
  task automatic pulse_start();
    @(negedge clk);
    cal_if.start = 1'b1;
    @(negedge clk);
    cal_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int n;
    n = 1;
    while (!cal_if.done && n < DONE_AT + 200) begin
      cal_if.start = poke && (n == 100);
      @(negedge clk);
      n++;
    end
    cal_if.start = 1'b0;
    check(tag, n, DONE_AT);
  endtask

  task automatic check_locked(input string tag, input int a, input int c);
    check({tag, "_best_a"},   cal_if.best_taps_A, a);
    check({tag, "_best_clk"}, cal_if.best_taps_clk, c);
    check({tag, "_best_err"}, cal_if.best_err, 0);
    check({tag, "_taps_a"},   taps_A, a);
    check({tag, "_taps_clk"}, taps_clk, c);
    check({tag, "_busy"},     cal_if.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_taps_clk"}, taps_clk, 0);
    check({tag, "_taps_a"},   taps_A, 0);
    check({tag, "_busy"},     cal_if.busy, 0);
    check({tag, "_done"},     cal_if.done, 0);
    check({tag, "_best_clk"}, cal_if.best_taps_clk, 0);
    check({tag, "_best_a"},   cal_if.best_taps_A, 0);
    check({tag, "_best_err"}, cal_if.best_err, 0);
    check({tag, "_tvalid"},   cal_if.trace_valid, 0);
    check({tag, "_trace_hw"}, cal_if.trace_hw, 0);
  endtask

  initial begin
    int found;
    cal_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Single optimum, with an ignored start at cycle 100 of the sweep.
    mode = 0;
    pulse_start();
    check("opt_busy", cal_if.busy, 1);
    check("opt_taps0", {taps_A, taps_clk}, 0);
    wait_done("opt_done_lat", 1'b1);
    check_locked("opt", 5, 17);
    check("opt_tvalid", cal_if.trace_valid, 1);
    repeat (5) @(negedge clk);
    check("opt_hold", {taps_A, taps_clk}, {5'd5, 5'd17});

    // Trace latency: step sensor from 0 to all-ones while locked.
    mode = 3;
    manual_p = '0;
    repeat (3) @(negedge clk);
    check("trace_pre", cal_if.trace_hw, 0);
    manual_p = ONES48;
    @(negedge clk);
    check("trace_lat1", cal_if.trace_hw, 0);
    @(negedge clk);
    check("trace_lat2", cal_if.trace_hw, 48);
    check("trace_valid", cal_if.trace_valid, 1);

    // Restart from LOCKED into the tie-break pattern.
    mode = 1;
    pulse_start();
    check("restart_done", cal_if.done, 0);
    check("restart_busy", cal_if.busy, 1);
    wait_done("tie_done_lat", 1'b0);
    check_locked("tie", 2, 3);

    // Mixed samples: every point averages exactly the target.
    mode = 2;
    pulse_start();
    wait_done("mix_done_lat", 1'b0);
    check_locked("mix", 0, 0);

    // Reset during ACCUM at point (1,4).
    mode = 0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 40 * PT && found == 0; i++) begin
      @(negedge clk);
      if (taps_A == 5'd1 && taps_clk == 5'd4 && dbg_state == ST_ACCUM) found = 1;
    end
    check("mid_accum_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    check("rerun_busy", cal_if.busy, 1);
    check("rerun_taps0", {taps_A, taps_clk}, 0);
    repeat (PT) @(negedge clk);
    check("rerun_taps1", {taps_A, taps_clk}, {5'd0, 5'd1});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
